// File: rtl/led_ctrl_pkg.sv
// Shared types and decode helpers for the MusicBox LED pattern sequencer.
package led_ctrl_pkg;

  localparam int DUTY_W     = 8;
  localparam int MODE_IDX_W = 3;

  // Mode-LED index meaning "no mode LED is highlighted" (IDLE).
  localparam logic [MODE_IDX_W-1:0] MODE_LED_NONE = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SONG0    = 3'd1,
    ST_SONG1    = 3'd2,
    ST_PLAY_REC = 3'd3,
    ST_MAKE_REC = 3'd4,
    ST_BEE      = 3'd5
  } mb_state_e;

  // Colour enable mask: bit 0 = R, bit 1 = G, bit 2 = B (matches channel index).
  typedef logic [2:0] rgb_mask_t;

  localparam rgb_mask_t MASK_IDLE     = 3'b111;
  localparam rgb_mask_t MASK_SONG0    = 3'b010;
  localparam rgb_mask_t MASK_SONG1    = 3'b100;
  localparam rgb_mask_t MASK_PLAY_REC = 3'b110;
  localparam rgb_mask_t MASK_MAKE_REC = 3'b001;
  localparam rgb_mask_t MASK_BEE      = 3'b011;

  // Raw controller state to enum; unknown encodings behave as IDLE.
  function automatic mb_state_e decode_state(input logic [4:0] raw);
    mb_state_e s;
    case (raw)
      5'd1:    s = ST_SONG0;
      5'd2:    s = ST_SONG1;
      5'd3:    s = ST_PLAY_REC;
      5'd4:    s = ST_MAKE_REC;
      5'd5:    s = ST_BEE;
      default: s = ST_IDLE;
    endcase
    return s;
  endfunction

  function automatic rgb_mask_t state_mask(input mb_state_e s);
    rgb_mask_t m;
    case (s)
      ST_SONG0:    m = MASK_SONG0;
      ST_SONG1:    m = MASK_SONG1;
      ST_PLAY_REC: m = MASK_PLAY_REC;
      ST_MAKE_REC: m = MASK_MAKE_REC;
      ST_BEE:      m = MASK_BEE;
      default:     m = MASK_IDLE;
    endcase
    return m;
  endfunction

  // Which mode LED breathes in a given state.
  function automatic logic [MODE_IDX_W-1:0] state_mode_led(input mb_state_e s);
    logic [MODE_IDX_W-1:0] idx;
    case (s)
      ST_SONG0:    idx = 3'd0;
      ST_SONG1:    idx = 3'd1;
      ST_MAKE_REC: idx = 3'd2;
      ST_PLAY_REC: idx = 3'd3;
      ST_BEE:      idx = 3'd4;
      default:     idx = MODE_LED_NONE;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/led_breath_gen.sv
// Tick-driven triangle generator bouncing between BREATH_MIN and BREATH_MAX.
// A synchronous clear parks it at BREATH_MIN heading up and wins over a tick.
module led_breath_gen
  import led_ctrl_pkg::*;
#(
  parameter int BREATH_MIN  = 16,
  parameter int BREATH_MAX  = 240,
  parameter int BREATH_STEP = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              clear,
  output logic [DUTY_W-1:0] breath
);

  logic [DUTY_W-1:0] breath_q, breath_d;
  logic              dir_down_q, dir_down_d;
  logic [DUTY_W:0]   up_sum;

  // Next breath level: clear first, otherwise one step per tick with end clamping.
  always_comb begin
    breath_d   = breath_q;
    dir_down_d = dir_down_q;
    up_sum     = {1'b0, breath_q} + (DUTY_W+1)'(BREATH_STEP);
    if (clear) begin
      breath_d   = DUTY_W'(BREATH_MIN);
      dir_down_d = 1'b0;
    end else if (tick) begin
      if (!dir_down_q) begin
        if (up_sum >= (DUTY_W+1)'(BREATH_MAX)) begin
          breath_d   = DUTY_W'(BREATH_MAX);
          dir_down_d = 1'b1;
        end else begin
          breath_d = up_sum[DUTY_W-1:0];
        end
      end else begin
        // Compare before subtracting so the level never wraps.
        if ({1'b0, breath_q} <= (DUTY_W+1)'(BREATH_MIN + BREATH_STEP)) begin
          breath_d   = DUTY_W'(BREATH_MIN);
          dir_down_d = 1'b0;
        end else begin
          breath_d = breath_q - DUTY_W'(BREATH_STEP);
        end
      end
    end
  end

  // Breath level and direction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      breath_q   <= DUTY_W'(BREATH_MIN);
      dir_down_q <= 1'b0;
    end else begin
      breath_q   <= breath_d;
      dir_down_q <= dir_down_d;
    end
  end

  assign breath = breath_q;

endmodule

// File: rtl/led_pattern_sequencer.sv
// Duty-cycle sequencer for the 6 RGB music-key LEDs and 5 mode-key LEDs:
// press flash/decay envelopes, chase in Bee mode, breathing active mode LED.
module led_pattern_sequencer
  import led_ctrl_pkg::*;
#(
  parameter int NUM_KEYS    = 6,
  parameter int NUM_MODES   = 5,
  parameter int IDLE_DUTY   = 32,
  parameter int PRESS_DUTY  = 255,
  parameter int DECAY_STEP  = 4,
  parameter int BREATH_MIN  = 16,
  parameter int BREATH_MAX  = 240,
  parameter int BREATH_STEP = 2,
  parameter int CHASE_TICKS = 150
) (
  input  logic                                     CLK_50Mhz,
  input  logic                                     reset_n,
  input  logic                                     tick_1Khz,
  input  logic [4:0]                               currentState,
  input  logic [NUM_KEYS-1:0]                      input_MusicKey,
  output logic [NUM_KEYS-1:0][2:0][DUTY_W-1:0]     musicKeys_RGBColor,
  output logic [NUM_MODES-1:0][DUTY_W-1:0]         modeKeys_RGBColor
);

  localparam int CIDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int CNT_W  = (CHASE_TICKS > 1) ? $clog2(CHASE_TICKS) : 1;

  logic [4:0]                           state_q, state_d;
  logic [NUM_KEYS-1:0][DUTY_W-1:0]      env_q, env_d;
  logic [CIDX_W-1:0]                    chase_idx_q, chase_idx_d;
  logic [CNT_W-1:0]                     chase_cnt_q, chase_cnt_d;
  logic [NUM_KEYS-1:0][2:0][DUTY_W-1:0] music_q, music_d;
  logic [NUM_MODES-1:0][DUTY_W-1:0]     mode_q, mode_d;

  mb_state_e              cur_state;
  mb_state_e              reg_state;
  logic                   state_chg;
  logic                   key_accept;
  logic                   in_bee;
  logic [DUTY_W-1:0]      breath;
  rgb_mask_t              out_mask;
  logic [MODE_IDX_W-1:0]  out_mode_idx;

  assign cur_state    = decode_state(currentState);
  assign reg_state    = decode_state(state_q);
  assign state_chg    = (currentState != state_q);
  assign key_accept   = (cur_state == ST_IDLE) || (cur_state == ST_MAKE_REC);
  assign in_bee       = (cur_state == ST_BEE);
  assign out_mask     = state_mask(reg_state);
  assign out_mode_idx = state_mode_led(reg_state);

  // Breathing restarts on every state change and stays parked while IDLE.
  led_breath_gen #(
    .BREATH_MIN  (BREATH_MIN),
    .BREATH_MAX  (BREATH_MAX),
    .BREATH_STEP (BREATH_STEP)
  ) u_breath (
    .clk    (CLK_50Mhz),
    .rst_n  (reset_n),
    .tick   (tick_1Khz),
    .clear  (state_chg || (cur_state == ST_IDLE)),
    .breath (breath)
  );

  // Track the raw controller state so changes can be detected.
  always_comb begin
    state_d = currentState;
  end

  // Per-key envelope: press beats chase hit beats decay toward IDLE_DUTY.
  always_comb begin
    env_d = env_q;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (key_accept && input_MusicKey[k]) begin
        env_d[k] = DUTY_W'(PRESS_DUTY);
      end else if (in_bee && tick_1Khz && (chase_idx_q == CIDX_W'(k))) begin
        env_d[k] = DUTY_W'(PRESS_DUTY);
      end else if (tick_1Khz) begin
        if (env_q[k] <= DUTY_W'(IDLE_DUTY + DECAY_STEP)) begin
          env_d[k] = DUTY_W'(IDLE_DUTY);
        end else begin
          env_d[k] = env_q[k] - DUTY_W'(DECAY_STEP);
        end
      end
    end
  end

  // Chase position: restarts on state change, advances every CHASE_TICKS ticks in BEE.
  always_comb begin
    chase_idx_d = chase_idx_q;
    chase_cnt_d = chase_cnt_q;
    if (state_chg) begin
      chase_idx_d = '0;
      chase_cnt_d = '0;
    end else if (in_bee && tick_1Khz) begin
      if (chase_cnt_q == CNT_W'(CHASE_TICKS - 1)) begin
        chase_cnt_d = '0;
        chase_idx_d = (chase_idx_q == CIDX_W'(NUM_KEYS - 1)) ? '0
                                                              : chase_idx_q + CIDX_W'(1);
      end else begin
        chase_cnt_d = chase_cnt_q + CNT_W'(1);
      end
    end
  end

  // Output duties from the registered state, envelopes and breath level.
  always_comb begin
    music_d = '0;
    mode_d  = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      for (int c = 0; c < 3; c++) begin
        music_d[k][c] = out_mask[c] ? env_q[k] : '0;
      end
    end
    for (int m = 0; m < NUM_MODES; m++) begin
      mode_d[m] = (out_mode_idx == MODE_IDX_W'(m)) ? breath : DUTY_W'(IDLE_DUTY);
    end
  end

  // All sequencer and output registers.
  always_ff @(posedge CLK_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= '0;
      chase_idx_q <= '0;
      chase_cnt_q <= '0;
      music_q     <= '0;
      mode_q      <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        env_q[k] <= DUTY_W'(IDLE_DUTY);
      end
    end else begin
      state_q     <= state_d;
      env_q       <= env_d;
      chase_idx_q <= chase_idx_d;
      chase_cnt_q <= chase_cnt_d;
      music_q     <= music_d;
      mode_q      <= mode_d;
    end
  end

  assign musicKeys_RGBColor = music_q;
  assign modeKeys_RGBColor  = mode_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: cycle model feeding a scoreboard queue,
// plus directed checks of the key behaviours against fixed values.
module tb_led_pattern_sequencer;

  localparam int VW = 184;
  typedef logic [VW-1:0] vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick = 1'b0;
  logic [4:0] st = '0;
  logic [5:0] keys = '0;
  logic [5:0][2:0][7:0] music;
  logic [4:0][7:0]      mode;

  always #10 clk = ~clk;

  led_pattern_sequencer dut (
    .CLK_50Mhz          (clk),
    .reset_n            (rst_n),
    .tick_1Khz          (tick),
    .currentState       (st),
    .input_MusicKey     (keys),
    .musicKeys_RGBColor (music),
    .modeKeys_RGBColor  (mode)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference state
  int   m_env [6];
  int   m_breath;
  bit   m_down;
  int   m_cidx;
  int   m_ccnt;
  logic [4:0] m_st;
  vec_t sb [$];

  task automatic check(input string tag, input vec_t act, input vec_t exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 6; k++) m_env[k] = 32;
    m_breath = 16;
    m_down   = 1'b0;
    m_cidx   = 0;
    m_ccnt   = 0;
    m_st     = '0;
    sb.delete();
  endtask

  function automatic vec_t model_out();
    logic [5:0][2:0][7:0] mu;
    logic [4:0][7:0]      mo;
    logic [2:0]           msk;
    int ds;
    int li;
    ds = (m_st <= 5) ? int'(m_st) : 0;
    case (ds)
      1: begin msk = 3'b010; li = 0; end
      2: begin msk = 3'b100; li = 1; end
      3: begin msk = 3'b110; li = 3; end
      4: begin msk = 3'b001; li = 2; end
      5: begin msk = 3'b011; li = 4; end
      default: begin msk = 3'b111; li = -1; end
    endcase
    for (int k = 0; k < 6; k++)
      for (int c = 0; c < 3; c++)
        mu[k][c] = msk[c] ? 8'(m_env[k]) : 8'd0;
    for (int i = 0; i < 5; i++)
      mo[i] = (i == li) ? 8'(m_breath) : 8'd32;
    return {mu, mo};
  endfunction

  task automatic model_step();
    int ds;
    bit chg;
    bit acc;
    ds  = (st <= 5) ? int'(st) : 0;
    chg = (st != m_st);
    acc = (ds == 0) || (ds == 4);
    for (int k = 0; k < 6; k++) begin
      if (acc && keys[k]) m_env[k] = 255;
      else if (ds == 5 && tick && k == m_cidx) m_env[k] = 255;
      else if (tick) m_env[k] = (m_env[k] - 4 < 32) ? 32 : m_env[k] - 4;
    end
    if (chg) begin
      m_cidx = 0;
      m_ccnt = 0;
    end else if (ds == 5 && tick) begin
      if (m_ccnt == 149) begin
        m_ccnt = 0;
        m_cidx = (m_cidx == 5) ? 0 : m_cidx + 1;
      end else m_ccnt++;
    end
    if (chg || ds == 0) begin
      m_breath = 16;
      m_down   = 1'b0;
    end else if (tick) begin
      if (!m_down) begin
        if (m_breath + 2 >= 240) begin m_breath = 240; m_down = 1'b1; end
        else m_breath += 2;
      end else begin
        if (m_breath - 2 <= 16) begin m_breath = 16; m_down = 1'b0; end
        else m_breath -= 2;
      end
    end
    m_st = st;
    sb.push_back(model_out());
  endtask

  // Called at a falling edge: compare the due entry, drive, predict, advance one clock.
  task automatic step(input bit tk);
    vec_t e;
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      check("scoreboard", vec_t'({music, mode}), e);
    end
    tick = tk;
    model_step();
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1);
      step(1'b0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #4;
    check("reset_music", vec_t'(music), vec_t'(0));
    check("reset_mode", vec_t'(mode), vec_t'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // IDLE, no keys
    step(1'b0);
    step(1'b0);
    check("idle_music", vec_t'(music), vec_t'({18{8'd32}}));
    check("idle_mode", vec_t'(mode), vec_t'({5{8'd32}}));

    // Press key 2 for one clock, then decay to the floor
    keys = 6'b000100;
    step(1'b0);
    keys = '0;
    step(1'b0);
    check("press_k2", vec_t'(music[2]), vec_t'(24'hFFFFFF));
    ticks(55);
    check("decay_55", vec_t'(music[2][0]), vec_t'(8'd35));
    ticks(1);
    check("decay_56", vec_t'(music[2][0]), vec_t'(8'd32));
    ticks(1);
    check("decay_57", vec_t'(music[2][0]), vec_t'(8'd32));

    // SONG0: keys ignored, green only, mode LED 0 breathes
    st = 5'd1;
    step(1'b0);
    keys = 6'b000001;
    step(1'b0);
    keys = '0;
    step(1'b0);
    check("song0_k0", vec_t'(music[0]), vec_t'(24'h002000));
    check("song0_mode", vec_t'(mode), vec_t'({8'd32, 8'd32, 8'd32, 8'd32, 8'd16}));
    for (int i = 1; i <= 112; i++) begin
      ticks(1);
      check("breath_up", vec_t'(mode[0]), vec_t'(16 + 2 * i));
    end
    ticks(1);
    check("breath_rev", vec_t'(mode[0]), vec_t'(8'd238));

    // BEE: chase hits, advance and wrap
    st = 5'd5;
    step(1'b0);
    step(1'b0);
    ticks(1);
    check("bee_k0", vec_t'(music[0]), vec_t'(24'h00FFFF));
    check("bee_breath", vec_t'(mode[4]), vec_t'(8'd18));
    ticks(149);
    ticks(1);
    check("chase_k1", vec_t'(music[1]), vec_t'(24'h00FFFF));
    ticks(749);
    check("chase_k0_low", vec_t'(music[0][0]), vec_t'(8'd32));
    ticks(1);
    check("chase_wrap", vec_t'(music[0]), vec_t'(24'h00FFFF));

    // SONG1 up to breath 200, then MAKE_REC on a tick clock
    st = 5'd2;
    step(1'b0);
    ticks(92);
    check("song1_200", vec_t'(mode[1]), vec_t'(8'd200));
    st = 5'd4;
    step(1'b1);
    step(1'b0);
    check("mrec_restart", vec_t'(mode[2]), vec_t'(8'd16));
    check("mrec_m1", vec_t'(mode[1]), vec_t'(8'd32));
    ticks(1);
    check("mrec_step", vec_t'(mode[2]), vec_t'(8'd18));
    keys = 6'b001000;
    step(1'b0);
    keys = '0;
    step(1'b0);
    check("mrec_k3", vec_t'(music[3]), vec_t'(24'h0000FF));

    // Unknown state code behaves as IDLE
    st = 5'd9;
    step(1'b0);
    step(1'b0);
    check("bad_state_mode", vec_t'(mode), vec_t'({5{8'd32}}));
    check("bad_state_k0", vec_t'(music[0]), vec_t'(24'h202020));

    // Random multi-key activity in the two key-accepting states
    st = 5'd0;
    for (int i = 0; i < 40; i++) begin
      keys = 6'($urandom);
      step(1'($urandom_range(0, 1)));
    end
    st = 5'd4;
    for (int i = 0; i < 40; i++) begin
      keys = 6'($urandom);
      step(1'($urandom_range(0, 1)));
    end
    keys = '0;

    // Asynchronous reset in the middle of BEE
    st = 5'd5;
    step(1'b0);
    ticks(200);
    #3 rst_n = 1'b0;
    #1;
    check("async_music", vec_t'(music), vec_t'(0));
    check("async_mode", vec_t'(mode), vec_t'(0));
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0);
    step(1'b0);
    ticks(1);
    check("restart_k0", vec_t'(music[0]), vec_t'(24'h00FFFF));
    check("restart_k1", vec_t'(music[1]), vec_t'(24'h002020));
    step(1'b0);
    step(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
- Generates the duty-cycle values for the 6 RGB music-key LEDs and the 5 mode-key LEDs.
- Inputs are the MusicBox state, live key presses and a 1 kHz tick.
- Outputs connect directly to the duty inputs of the existing rgb_led PWM instances, replacing the current constant half-brightness assignments.
- Sequences key-press flash/decay envelopes, a breathing indicator on the active mode key, and a chase pattern in Bee mode.

Parameters:
- NUM_KEYS, 6, number of music keys.
- NUM_MODES, 5, number of mode keys.
- IDLE_DUTY, 32, resting brightness (8-bit).
- PRESS_DUTY, 255, brightness on press or chase hit.
- DECAY_STEP, 4, envelope decrement per tick.
- BREATH_MIN, 16, breathing floor.
- BREATH_MAX, 240, breathing ceiling.
- BREATH_STEP, 2, breathing increment per tick.
- CHASE_TICKS, 150, ticks per chase step in Bee mode.

Ports:
- CLK_50Mhz  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- tick_1Khz  in  1  single-cycle enable pulse, synchronous to CLK_50Mhz.
- currentState  in  5  state from MusicBoxStateController.
- input_MusicKey  in  6  debounced key levels, 1 = pressed.
- musicKeys_RGBColor  out  6x3x8  duty per key, indexed [key][0=R,1=G,2=B].
- modeKeys_RGBColor  out  5x8  duty per mode LED.

Behaviour:
- Reset:
  - env[k] = IDLE_DUTY.
  - breath = BREATH_MIN, dir = up.
  - chase_idx = 0, chase_cnt = 0.
  - All outputs = 0.
  - First valid outputs appear 2 clocks after reset release.
- State decode:
  - 0 IDLE; 1 SONG0; 2 SONG1; 3 PLAY_REC; 4 MAKE_REC; 5 BEE.
  - Any other value is treated as IDLE.
- Colour mask per state (R,G,B): IDLE 111, SONG0 010, SONG1 001, PLAY_REC 011, MAKE_REC 100, BEE 110.
- Key input is accepted in IDLE and MAKE_REC only. In other states input_MusicKey is ignored.
- Envelope, every clock, for each key k:
  - If key accepted and input_MusicKey[k] = 1: env[k] <= PRESS_DUTY (no wait for tick).
  - Else, in BEE on a tick where k == chase_idx: env[k] <= PRESS_DUTY.
  - Else, on tick: env[k] <= max(env[k] - DECAY_STEP, IDLE_DUTY), saturating with no wrap below IDLE_DUTY.
  - Else: hold.
- Chase (BEE only): on tick, chase_cnt++. When chase_cnt == CHASE_TICKS-1, chase_cnt <= 0 and chase_idx <= (chase_idx == NUM_KEYS-1) ? 0 : chase_idx+1.
- Breathing, on tick when state != IDLE:
  - Dir up: breath + BREATH_STEP >= BREATH_MAX gives breath = BREATH_MAX, dir = down. Otherwise add BREATH_STEP.
  - Dir down: breath - BREATH_STEP <= BREATH_MIN gives breath = BREATH_MIN, dir = up. Otherwise subtract BREATH_STEP.
  - In IDLE: breath is held at BREATH_MIN, dir = up.
- State change (currentState differs from its registered copy):
  - Same clock: breath = BREATH_MIN, dir = up, chase_idx = 0, chase_cnt = 0.
  - Envelopes are not reset and decay naturally.
  - A tick coinciding with the state change is consumed by the reset action only.
- Output register, updated every clock:
  - musicKeys_RGBColor[k][c] = mask[c] ? env[k] : 0.
  - Mode LED mapping: SONG0 → LED 0, SONG1 → LED 1, MAKE_REC → LED 2, PLAY_REC → LED 3, BEE → LED 4.
  - The mapped mode LED = breath; all other mode LEDs = IDLE_DUTY.
  - In IDLE, all mode LEDs = IDLE_DUTY.
- Latency: input/tick sampled at edge E, internal register at E, output at E+1 (2 clocks input-to-output).
- Simultaneous events: press beats chase beats decay. Multiple keys are independent.
- Reset mid-operation: all registers return to reset values immediately (asynchronous).

Decomposition:
- Package led_ctrl_pkg holds:
  - State enum (IDLE..BEE).
  - Colour-mask constants.
  - State→mask function.
  - State→mode-LED-index function.
- Sub-module led_breath_gen: tick-driven triangle generator with breath/dir registers and a sync clear input.
- Envelope and chase logic stay in the top module.

Test Plan:
- Reset, then release; IDLE, no keys → after 2 clocks, all music channels = 32 and all mode LEDs = 32.
- IDLE, press key 2 for 1 clock → key 2 RGB = 255,255,255 two clocks later. After 56 ticks it equals 32 and holds (saturation check at tick 56/57).
- State = 1 (SONG0), press key 0 → ignored, key 0 R = B = 0, G = 32. Mode LED 0 climbs by 2 per tick: 16, 18, …, 240, then 238 (reversal). Mode LEDs 1–4 = 32.
- State = 5 (BEE) → key 0 R = G = 255, B = 0 on first tick. chase_idx advances to 1 after 150 ticks, wraps 5 → 0 after 900 ticks. Mode LED 4 breathes.
- SONG1 with breath = 200, switch to MAKE_REC on a tick clock → breath restarts at 16 on mode LED 2. Mode LED 1 = 32. Key presses now produce R = 255, G = B = 0.
- Assert reset_n low mid-BEE between clock edges → outputs 0 immediately, without waiting for a clock edge. After release, chase restarts at key 0.
